// File: rtl/grid_row_scanner_if.sv
// Control/data bundle between the Life datapath and the LED row scanner.
// The master drives the generation vector and scan enable; the slave returns the matrix drive.
interface grid_row_scanner_if;
  logic        en;
  logic [48:0] grid;
  logic        grid_load;
  logic [6:0]  row_n;
  logic [6:0]  col;
  logic        frame_done;
  logic        load_ack;
  logic [5:0]  population;

  modport master (
    output en, grid, grid_load,
    input  row_n, col, frame_done, load_ack, population
  );

  modport slave (
    input  en, grid, grid_load,
    output row_n, col, frame_done, load_ack, population
  );
endinterface

// File: rtl/grid_row_scanner.sv
// Multiplexed 7x7 LED row scanner with a double-buffered, tear-free frame and population count.
// All outputs registered; the frame buffer only changes in IDLE or at the end of row 6.
module grid_row_scanner #(
  parameter int DWELL = 1000,
  parameter int BLANK = 4
) (
  input  logic                clka,
  input  logic                rst_n,
  grid_row_scanner_if.slave   bus
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t        state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [48:0]   sh_q, sh_d;
  logic          pend_q, pend_d;
  logic [48:0]   fb_q, fb_d;
  logic [5:0]    pop_q, pop_d;
  logic [6:0]    row_n_q, row_n_d;
  logic [6:0]    col_q, col_d;
  logic          fd_q, fd_d;
  logic          ack_q, ack_d;
  logic          row_end;
  logic          frame_end;

  function automatic logic [5:0] popcount49(input logic [48:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 49; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  assign row_end   = (state_q == S_SHOW) && (cnt_q == DWELL_LAST);
  assign frame_end = row_end && (row_q == 3'd6);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    pend_d  = pend_q;
    fb_d    = fb_q;
    pop_d   = pop_q;
    fd_d    = 1'b0;
    ack_d   = 1'b0;
    row_n_d = 7'h7F;
    col_d   = 7'h00;

    case (state_q)
      S_IDLE: begin
        row_d = 3'd0;
        cnt_d = '0;
        if (bus.en) state_d = S_BLANK;
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = S_SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (row_end) begin
          cnt_d   = '0;
          state_d = S_BLANK;
          if (row_q == 3'd6) begin
            row_d = 3'd0;
            fd_d  = 1'b1;
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!bus.en) begin
      state_d = S_IDLE;
      row_d   = 3'd0;
      cnt_d   = '0;
      fd_d    = 1'b0;
    end

    // A load landing exactly on the frame end skips the shadow so it shows next frame.
    if (frame_end && bus.grid_load) begin
      fb_d   = bus.grid;
      sh_d   = bus.grid;
      pop_d  = popcount49(bus.grid);
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end else begin
      if ((state_q == S_IDLE || frame_end) && pend_q) begin
        fb_d   = sh_q;
        pop_d  = popcount49(sh_q);
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end
      if (bus.grid_load) begin
        sh_d   = bus.grid;
        pend_d = 1'b1;
      end
    end

    // SHOW is only entered from BLANK, where fb is stable, so fb_q is the right source.
    if (state_d == S_SHOW) begin
      row_n_d = ~(7'd1 << row_d);
      col_d   = fb_q[int'(row_d) * 7 +: 7];
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= 3'd0;
      cnt_q   <= '0;
      sh_q    <= '0;
      pend_q  <= 1'b0;
      fb_q    <= '0;
      pop_q   <= 6'd0;
      row_n_q <= 7'h7F;
      col_q   <= 7'h00;
      fd_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      pend_q  <= pend_d;
      fb_q    <= fb_d;
      pop_q   <= pop_d;
      row_n_q <= row_n_d;
      col_q   <= col_d;
      fd_q    <= fd_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.row_n      = row_n_q;
  assign bus.col        = col_q;
  assign bus.frame_done = fd_q;
  assign bus.load_ack   = ack_q;
  assign bus.population = pop_q;

endmodule

// File: tb/tb_grid_row_scanner.sv
// Bench for grid_row_scanner: a frame-arithmetic reference model predicts every output each cycle.
module tb_grid_row_scanner;
  localparam int D  = 4;
  localparam int B  = 1;
  localparam int RP = D + B;
  localparam int FP = 7 * RP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  grid_row_scanner_if bus();

  grid_row_scanner #(.DWELL(D), .BLANK(B)) dut (
    .clka  (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: mk counts edges since scanning started (0 = idle); position in frame is arithmetic.
  int          mk;
  int          mq;
  int          mrow;
  bit          mlit;
  bit          fend;
  logic [48:0] mfb, msh;
  logic        mpend, mack, mfd;
  logic [5:0]  mpop;
  logic [6:0]  mrow_n, mcol;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk = 0; mfb = '0; msh = '0; mpend = 1'b0; mack = 1'b0; mfd = 1'b0;
      mpop = 6'd0; mrow_n = 7'h7F; mcol = 7'h00; mrow = 0; mlit = 1'b0;
    end else begin
      mack = 1'b0;
      mfd  = 1'b0;
      fend = (mk > 0) && (((mk - 1) % FP) == FP - 1);
      if (fend && bus.grid_load) begin
        mfb = bus.grid; msh = bus.grid; mpend = 1'b0; mack = 1'b1;
      end else begin
        if ((mk == 0 || fend) && mpend) begin
          mfb = msh; mpend = 1'b0; mack = 1'b1;
        end
        if (bus.grid_load) begin
          msh = bus.grid; mpend = 1'b1;
        end
      end
      mpop = 6'($countones(mfb));
      if (!bus.en) mk = 0;
      else begin
        if (fend) mfd = 1'b1;
        mk = mk + 1;
      end
      mrow_n = 7'h7F; mcol = 7'h00; mrow = 0; mlit = 1'b0;
      if (mk > 0) begin
        mq   = (mk - 1) % FP;
        mrow = mq / RP;
        if ((mq % RP) >= B) begin
          mlit   = 1'b1;
          mrow_n = ~(7'd1 << mrow);
          mcol   = mfb[mrow * 7 +: 7];
        end
      end
    end
  end

  wire  [21:0] obs = {bus.row_n, bus.col, bus.frame_done, bus.load_ack, bus.population};
  logic [21:0] exp_v;
  assign exp_v = {mrow_n, mcol, mfd, mack, mpop};
  localparam logic [21:0] OFF_V = {7'h7F, 7'h00, 1'b0, 1'b0, 6'd0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.en = 1'b0; bus.grid = '0; bus.grid_load = 1'b0;
    #12;
    n_cmp++;
    if (obs !== OFF_V) begin n_bad++; $display("FAIL reset_state: got %h want %h", obs, OFF_V); end
    rst_n = 1'b1;
    repeat (4) begin
      step();
      n_cmp++;
      if (obs !== OFF_V) begin n_bad++; $display("FAIL reset_idle: got %h want %h", obs, OFF_V); end
    end
  endtask

  task automatic test_load_idle();
    int acks = 0;
    int fds  = 0;
    bus.en = 1'b0; bus.grid = {49{1'b1}}; bus.grid_load = 1'b1;
    step();
    bus.grid_load = 1'b0;
    if (bus.load_ack) acks++;
    repeat (4) begin
      step();
      if (bus.load_ack) acks++;
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL idle_load_model: got %h want %h", obs, exp_v); end
    end
    n_cmp++;
    if (acks != 1) begin n_bad++; $display("FAIL idle_load_ack_count: got %0d want 1", acks); end
    n_cmp++;
    if (bus.population !== 6'd49) begin n_bad++; $display("FAIL idle_load_pop: got %0d want 49", bus.population); end
    bus.en = 1'b1;
    step();
    step();
    n_cmp++;
    if ({bus.row_n, bus.col} !== {7'h7E, 7'h7F}) begin
      n_bad++; $display("FAIL first_row_lit: got %h/%h want 7e/7f", bus.row_n, bus.col);
    end
    repeat (70) begin
      step();
      if (bus.frame_done) fds++;
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL scan_model: got %h want %h", obs, exp_v); end
    end
    n_cmp++;
    if (fds != 2) begin n_bad++; $display("FAIL frame_done_count: got %0d want 2", fds); end
  endtask

  task automatic test_tear_free();
    logic [48:0] gl;
    bit found = 1'b0;
    bit acked = 1'b0;
    gl = '0; gl[1] = 1'b1; gl[9] = 1'b1; gl[14] = 1'b1; gl[15] = 1'b1; gl[16] = 1'b1;
    bus.en = 1'b0; bus.grid = gl; bus.grid_load = 1'b1;
    step();
    bus.grid_load = 1'b0;
    repeat (3) step();
    bus.en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL tear_pre: got %h want %h", obs, exp_v); end
      if (mlit && mrow == 2) begin found = 1'b1; break; end
    end
    if (!found) begin n_cmp++; n_bad++; $display("FAIL tear_wait_row2: got timeout want row 2"); end
    bus.grid = '0; bus.grid_load = 1'b1;
    step();
    bus.grid_load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL tear_model: got %h want %h", obs, exp_v); end
      if (bus.load_ack) begin
        acked = 1'b1;
        n_cmp++;
        if (bus.frame_done !== 1'b1) begin n_bad++; $display("FAIL ack_with_frame_done: got %b want 1", bus.frame_done); end
        break;
      end
      if (mlit && mrow >= 3) begin
        n_cmp++;
        if (bus.col !== gl[mrow * 7 +: 7]) begin
          n_bad++; $display("FAIL tear_old_frame row%0d: got %h want %h", mrow, bus.col, gl[mrow * 7 +: 7]);
        end
      end
      step();
    end
    if (!acked) begin n_cmp++; n_bad++; $display("FAIL tear_ack: got timeout want ack"); end
    repeat (2) step();
    n_cmp++;
    if ({bus.row_n, bus.col} !== {7'h7E, 7'h00}) begin
      n_bad++; $display("FAIL tear_new_frame: got %h/%h want 7e/00", bus.row_n, bus.col);
    end
  endtask

  task automatic test_latest_wins();
    logic [48:0] ga, gb;
    int acks = 0;
    bit found = 1'b0;
    ga = {$urandom, $urandom} & {49{1'b1}};
    gb = {$urandom, $urandom} & {49{1'b1}};
    gb[0] = ~ga[0];
    for (int i = 0; i < 50; i++) begin
      step();
      if (mfd) begin found = 1'b1; break; end
    end
    if (!found) begin n_cmp++; n_bad++; $display("FAIL lw_wait_frame: got timeout want frame_done"); end
    repeat (4) step();
    bus.grid = ga; bus.grid_load = 1'b1;
    step();
    bus.grid_load = 1'b0;
    repeat (9) step();
    bus.grid = gb; bus.grid_load = 1'b1;
    step();
    bus.grid_load = 1'b0;
    repeat (22) begin
      step();
      if (bus.load_ack) acks++;
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL lw_model: got %h want %h", obs, exp_v); end
    end
    n_cmp++;
    if (acks != 1) begin n_bad++; $display("FAIL lw_ack_count: got %0d want 1", acks); end
    n_cmp++;
    if (bus.population !== 6'($countones(gb))) begin
      n_bad++; $display("FAIL lw_pop: got %0d want %0d", bus.population, $countones(gb));
    end
  endtask

  task automatic test_bypass();
    logic [48:0] gc;
    int acks = 0;
    bit found = 1'b0;
    gc = {$urandom, $urandom} & {49{1'b1}};
    gc[48] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (mk > 0 && ((mk - 1) % FP) == FP - 1) begin found = 1'b1; break; end
      step();
    end
    if (!found) begin n_cmp++; n_bad++; $display("FAIL bp_wait: got timeout want row6 end"); end
    bus.grid = gc; bus.grid_load = 1'b1;
    step();
    bus.grid_load = 1'b0;
    n_cmp++;
    if ({bus.load_ack, bus.frame_done} !== 2'b11) begin
      n_bad++; $display("FAIL bp_ack: got %b want 11", {bus.load_ack, bus.frame_done});
    end
    n_cmp++;
    if (bus.population !== 6'($countones(gc))) begin
      n_bad++; $display("FAIL bp_pop: got %0d want %0d", bus.population, $countones(gc));
    end
    repeat (FP + 2) begin
      step();
      if (bus.load_ack) acks++;
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL bp_model: got %h want %h", obs, exp_v); end
    end
    n_cmp++;
    if (acks != 0) begin n_bad++; $display("FAIL bp_no_pending: got %0d acks want 0", acks); end
  endtask

  task automatic test_enable_drop();
    bit found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (mlit && mrow == 4) begin found = 1'b1; break; end
    end
    if (!found) begin n_cmp++; n_bad++; $display("FAIL en_wait_row4: got timeout want row 4"); end
    bus.en = 1'b0;
    step();
    n_cmp++;
    if ({bus.row_n, bus.col} !== {7'h7F, 7'h00}) begin
      n_bad++; $display("FAIL en_drop_off: got %h/%h want 7f/00", bus.row_n, bus.col);
    end
    step();
    bus.en = 1'b1;
    step();
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL en_restart_blank: got %h want %h", obs, exp_v); end
    step();
    n_cmp++;
    if (bus.row_n !== 7'h7E) begin n_bad++; $display("FAIL en_restart_row0: got %h want 7e", bus.row_n); end
  endtask

  task automatic test_population();
    bit found = 1'b0;
    bus.en = 1'b0; bus.grid = '0; bus.grid_load = 1'b1;
    step();
    bus.grid_load = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (bus.population !== 6'd0) begin n_bad++; $display("FAIL pop_zero: got %0d want 0", bus.population); end
    bus.grid = 49'h1_0000_0000_0000; bus.grid_load = 1'b1;
    step();
    bus.grid_load = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (bus.population !== 6'd1) begin n_bad++; $display("FAIL pop_one: got %0d want 1", bus.population); end
    bus.en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pop_scan_model: got %h want %h", obs, exp_v); end
      if (mlit && mrow == 6) begin found = 1'b1; break; end
    end
    if (!found) begin n_cmp++; n_bad++; $display("FAIL pop_wait_row6: got timeout want row 6"); end
    n_cmp++;
    if ({bus.row_n, bus.col} !== {7'h3F, 7'h40}) begin
      n_bad++; $display("FAIL pop_bit48: got %h/%h want 3f/40", bus.row_n, bus.col);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.en        = ($urandom_range(0, 99) < 97);
      bus.grid_load = ($urandom_range(0, 15) == 0);
      bus.grid      = {$urandom, $urandom} & {49{1'b1}};
      step();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL random_model cycle %0d: got %h want %h", i, obs, exp_v); end
    end
    bus.grid_load = 1'b0;
  endtask

  task automatic test_reset_mid_show();
    bit found = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (mlit && bus.population != 6'd0) begin found = 1'b1; break; end
    end
    if (!found) begin n_cmp++; n_bad++; $display("FAIL rst_wait_show: got timeout want lit row"); end
    bus.grid = {49{1'b1}}; bus.grid_load = 1'b1;
    step();
    bus.grid_load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== OFF_V) begin n_bad++; $display("FAIL rst_mid_show: got %h want %h", obs, OFF_V); end
    bus.en = 1'b0;
    #1 rst_n = 1'b1;
    repeat (5) begin
      step();
      n_cmp++;
      if (obs !== OFF_V) begin n_bad++; $display("FAIL rst_discard_pend: got %h want %h", obs, OFF_V); end
    end
  endtask

  initial begin
    test_reset();
    test_load_idle();
    test_tear_free();
    test_latest_wins();
    test_bypass();
    test_enable_drop();
    test_population();
    test_random();
    test_reset_mid_show();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
